// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexed N-digit common-anode 7-segment scan driver with
//            double-buffered digits, hex/dec decode, blanking and blinking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int c_div_w = $clog2(REFRESH_DIV);
  localparam int c_idx_w = $clog2(NUM_DIGITS);
  localparam int c_frm_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0] c_dark = 7'b1111111;
  localparam logic [6:0] c_dash = 7'b0111111;
  localparam logic [NUM_DIGITS-1:0] c_an_one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [c_div_w-1:0]      r_div;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_frm_w-1:0]      r_frame;
  logic                    r_blink_on;
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [4*NUM_DIGITS-1:0] w_upper;
  logic [3:0]              w_nib;
  logic                    w_lz_dark;
  logic                    w_dark;
  logic [6:0]              w_seg;

  assign w_slot_end  = (r_div == c_div_w'(REFRESH_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == c_idx_w'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_frame    <= '0;
      r_blink_on <= 1'b1;
    end else begin
      if (w_slot_end) begin
        r_div <= '0;
        r_idx <= w_frame_end ? '0 : r_idx + c_idx_w'(1);
      end else begin
        r_div <= r_div + c_div_w'(1);
      end
      if (w_frame_end) begin
        if (r_frame == c_frm_w'(BLINK_FRAMES - 1)) begin
          r_frame    <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_frame <= r_frame + c_frm_w'(1);
        end
      end
    end
  end

  // A load coinciding with the frame boundary lands in pending only; active
  // takes the previous pending value so a frame never mixes two loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_valid  <= 1'b0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
    end else begin
      if (w_frame_end && r_pend_valid) begin
        r_act_digits <= r_pend_digits;
        r_act_dp     <= r_pend_dp;
      end
      if (load) begin
        r_pend_digits <= digits_in;
        r_pend_dp     <= dp_in;
        r_pend_valid  <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Nibbles at and above the scanned digit; all-zero means a leading zero.
  assign w_upper   = r_act_digits >> {r_idx, 2'b00};
  assign w_nib     = w_upper[3:0];
  assign w_lz_dark = lz_suppress && (r_idx != '0) && (w_upper == '0);
  assign w_dark    = blank_mask[r_idx] || (blink_mask[r_idx] && !r_blink_on) || w_lz_dark;

  always_comb begin
    w_seg = c_dark;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = hex_mode ? 7'b0001000 : c_dash;
      4'hB: w_seg = hex_mode ? 7'b0000011 : c_dash;
      4'hC: w_seg = hex_mode ? 7'b1000110 : c_dash;
      4'hD: w_seg = hex_mode ? 7'b0100001 : c_dash;
      4'hE: w_seg = hex_mode ? 7'b0000110 : c_dash;
      4'hF: w_seg = hex_mode ? 7'b0001110 : c_dash;
      default: w_seg = c_dark;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_dark) begin
      r_an  <= '1;
      r_seg <= c_dark;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(c_an_one << r_idx);
      r_seg <= w_seg;
      r_dp  <= ~r_act_dp[r_idx];
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Captures a packed nibble vector and scans one digit per refresh slot.
- Decodes each nibble to active-low segments, with hex/decimal modes, leading-zero suppression, per-digit blanking, blinking and decimal points.
- Sits between the game logic and the board display pins, replacing per-digit static decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clk cycles each digit stays selected (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- digits_in  input  4*NUM_DIGITS  packed nibbles; digit i = [4i+3:4i]; digit 0 = least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit (1 = lit).
- load  input  1  capture strobe for digits_in and dp_in.
- hex_mode  input  1  1 = show 10..15 as A b C d E F; 0 = show 10..15 as dash.
- lz_suppress  input  1  enable leading-zero blanking.
- blank_mask  input  NUM_DIGITS  1 = digit forced dark.
- blink_mask  input  NUM_DIGITS  1 = digit blinks.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- an  output  NUM_DIGITS  active-low anode select, one-hot-low when a digit is shown.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - div counter = 0, digit index idx = 0, frame counter = 0, blink phase = ON.
  - pending and active registers = 0; pending_valid = 0.
  - an = all 1, seg = 7'b1111111, dp = 1.
  - A reset mid-scan abandons the current state immediately.
- Refresh:
  - div counts 0..REFRESH_DIV-1.
  - When div = REFRESH_DIV-1: div <= 0 and idx <= (idx = NUM_DIGITS-1) ? 0 : idx+1.
  - The wrap of idx from NUM_DIGITS-1 to 0 is the frame boundary.
- Double buffering:
  - load = 1 captures digits_in/dp_in into pending and sets pending_valid.
  - At a frame boundary with pending_valid = 1: active <= pending and pending_valid <= 0.
  - If load and the frame boundary occur in the same cycle, active takes the old pending value. The new value goes to pending and pending_valid stays 1.
  - The display never mixes two loads within one frame.
- Blink:
  - The frame counter increments at each frame boundary.
  - At count BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
  - During the OFF phase, digits with blink_mask = 1 are dark.
- Leading-zero suppression, when lz_suppress = 1:
  - Digit i (i > 0) is dark if active nibble i = 0 and all nibbles j > i are 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - The dp of a suppressed digit is also dark.
- Decode:
  - 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - hex_mode = 1: A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - hex_mode = 0: 10..15 = 0111111 (dash).
  - Every code is fully specified; the decode creates no latch.
- Dark digit (blank_mask, blink OFF or suppressed): an = all 1, seg = 1111111, dp = 1.
- Output timing:
  - an, seg and dp are registered from idx, the active registers and the live mode/mask inputs.
  - Outputs reflect a change in idx or masks 1 cycle later.
  - Lit digit: an = ~(1 << idx), dp = ~active_dp[idx].

Test Plan:
- Reset/first scan (NUM_DIGITS=4, REFRESH_DIV=4): rst 2 cycles -> an = 1111, seg = 1111111. Release -> next cycle an = 1110, seg = 1000000. an walks 1101, 1011, 0111 every 4 cycles, then returns to 1110 after 16 cycles.
- Decode/hex: load digits_in = 16'hA9F1, hex_mode = 1 -> after the next frame boundary digits 0..3 show 1111001, 0001110, 0010000, 0001000. With hex_mode = 0, digits 1 and 3 show 0111111.
- Leading zeros: load 16'h0050, lz_suppress = 1 -> digits 3 and 2 dark (an = 1111), digit 1 = 0010010, digit 0 = 1000000. Load 16'h0000 -> only digit 0 lit with "0".
- Double buffer: load 16'h1234 mid-frame -> no digit changes until the frame boundary. Load 16'h5678 in the exact boundary cycle -> that frame shows 1234 and the next frame shows 5678.
- Blink/blank/dp (BLINK_FRAMES=2): blink_mask = 0001 -> digit 0 lit for 2 frames, dark for 2 frames, repeating. blank_mask = 0100 -> digit 2 always dark. dp_in = 0010 -> dp = 0 only while an = 1101.
- Reset mid-operation: assert rst while idx = 2 and pending_valid = 1 -> next cycle all outputs are at reset values. After release, active = 0 and display shows 0000, not the pending value.
